rr_mux: RTL
===========

Name: rr_mux

Overview:
- Parametrised, registered N-channel multiplexer; the next generation of the combinational 2:1 Mux.
- Selection is no longer a static sel input. The block arbitrates among CHANNELS valid/ready input streams using round-robin.
- The winning WIDTH-bit word is forwarded through a single output register stage with valid/ready backpressure.
- Used wherever several producers share one consumer, e.g. memory/IO bus sharing in the Hack system.

Parameters:
- WIDTH, 16: data width per channel, legal range 1..32.
- CHANNELS, 4: number of input channels, minimum 2, power of two not required.
- SELW, $clog2(CHANNELS): width of the channel index; derived, never overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  CHANNELS  bit i: channel i offers a word.
- in_data  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  bit i: channel i word accepted this cycle (when in_valid[i] is also high).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has top priority first.
  - Lock flag=0.
- Reset overrides all other events in the same cycle. Reset during operation discards the held word; out_valid is 0 after the edge.
- Load enable: load = ~out_valid | out_ready.
  - Gives full throughput: one word per cycle with no bubble while out_ready=1.
- Grant (combinational):
  - Search in_valid starting at ptr+1, wrapping modulo CHANNELS.
  - The first set bit is the winner g.
  - If no bit is set there is no grant.
- in_ready:
  - in_ready[g] = load, only when a grant exists.
  - All other in_ready bits are 0.
  - in_ready depends combinationally on in_valid and out_ready; there is no register between them.
- Transfer on a clock edge with a grant and load=1:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g.
- Drain on a clock edge with load=1 and no grant:
  - out_valid <= 0.
  - out_data and out_sel hold their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_sel stay stable.
  - All in_ready bits are 0.
  - ptr is unchanged.
- Latency: 1 cycle from input acceptance to out_valid.
- Fairness: a continuously valid channel waits at most CHANNELS-1 transfers.
- Simultaneous drain and accept in the same cycle is legal; out_valid stays 1 with the new word.
- in_valid deassertion: in_valid may drop without ever being accepted; the block has no memory of unaccepted requests.

Optional Feature:
- Macro: RR_MUX_LOCK_EN, enabling packet lock.
- When defined, an extra port is added: in_last  input  CHANNELS  (marks the final beat of a packet).
- Lock acquisition: an accepted beat from g with in_last[g]=0 sets lock=1, and the grant is pinned to g.
- Behaviour while locked:
  - Other channels see in_ready=0, even when g has in_valid=0 that cycle.
  - ptr is not updated until the lock releases.
- Release: an accepted beat with in_last[g]=1 clears lock and sets ptr <= g.
- Reset clears lock.
- When not defined: the in_last port is absent and every beat is arbitrated independently.

Test Plan:
1. Reset: hold reset 2 cycles with in_valid=4'b1111 and out_ready=1 -> out_valid=0, out_data=0, out_sel=0 after each edge. First grant after release goes to channel 0.
2. Single transfer: in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100 the same cycle. Next cycle out_valid=1, out_data=16'hBEEF, out_sel=2, then out_valid=0 one cycle later.
3. Round robin: in_valid=4'b1111 held, data = channel index, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
4. Backpressure: after the first word, hold out_ready=0 for 3 cycles -> out_data/out_sel constant and in_ready=0. Raising out_ready=1 accepts the next winner in the same cycle.
5. Sparse wrap: in_valid=4'b1010 held, out_ready=1 -> out_sel alternates 1,3,1,3.
6. Lock (RR_MUX_LOCK_EN): ch0 sends 3 beats with in_last=0,0,1 while ch1 stays valid; insert one in_valid[0]=0 gap mid-packet -> out_sel 0,0,0,1, and in_ready[1]=0 throughout the gap.

Source files
------------

// File: rtl/rr_mux_if.sv
// rr_mux_if: bundles CHANNELS valid/ready input streams and the output stream.
// Optional in_last port exists only when RR_MUX_LOCK_EN is defined.
interface rr_mux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
`ifdef RR_MUX_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
`endif
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
`ifdef RR_MUX_LOCK_EN
        output in_last,
`endif
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
`ifdef RR_MUX_LOCK_EN
        input  in_last,
`endif
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );
endinterface

// File: rtl/rr_mux.sv
// rr_mux: round-robin N:1 registered multiplexer with valid/ready handshake.
// Define RR_MUX_LOCK_EN to pin the grant for multi-beat packets (in_last).
module rr_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input logic   clk,
    input logic   reset,
    rr_mux_if.slave bus
);
    logic [SELW-1:0]     r_ptr;
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_sel;

    logic                w_load;
    logic                w_gnt_vld;
    logic [SELW-1:0]     w_gnt;
    logic [WIDTH-1:0]    w_gnt_data;
    logic [CHANNELS-1:0] w_rdy;
    logic                w_last;

`ifdef RR_MUX_LOCK_EN
    logic                r_lock;
    logic [SELW-1:0]     r_lock_ch;
`endif

    assign w_load = ~r_valid | bus.out_ready;

    // Grant: first valid channel after ptr, or the locked channel
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!w_gnt_vld && bus.in_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = SELW'(idx);
            end
        end
`ifdef RR_MUX_LOCK_EN
        if (r_lock) begin
            w_gnt_vld = bus.in_valid[r_lock_ch];
            w_gnt     = r_lock_ch;
        end
`endif
    end

    assign w_gnt_data = bus.in_data[int'(w_gnt)*WIDTH +: WIDTH];

`ifdef RR_MUX_LOCK_EN
    assign w_last = bus.in_last[w_gnt];
`else
    assign w_last = 1'b1;
`endif

    // Only the winner sees ready, and only when the output can load
    always_comb begin
        w_rdy = '0;
        if (w_gnt_vld) w_rdy[w_gnt] = w_load;
    end

    assign bus.in_ready  = w_rdy;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= SELW'(CHANNELS - 1);
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_gnt_data;
                r_sel   <= w_gnt;
                if (w_last) r_ptr <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    // Packet lock: held from a non-last accepted beat until the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_gnt_vld && w_load) begin
            r_lock    <= ~w_last;
            r_lock_ch <= w_gnt;
        end
    end
`endif
endmodule
